// File: rtl/imm_field_encoder.sv
// rtl/imm_field_encoder.sv - 64-bit constant to instruction immediate field encoder
// Optional IMM_ZERO_SKIP_EN: skip all-zero halfwords in IM (MOVZ/MOVK) sequences.
module imm_field_encoder #(
  parameter int NUM_HW = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [63:0] Imm64,
  input  logic [2:0]  Ctrl,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [25:0] Imm26,
  output logic        OutMovK,
  output logic        OutLast,
  output logic        RangeErr
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                  state_q;
  logic [25:0]             imm26_q;
  logic                    movk_q;
  logic                    last_q;
  logic                    rerr_q;
  logic [16*NUM_HW-1:0]    data_q;
`ifdef IMM_ZERO_SKIP_EN
  logic [NUM_HW-1:0]       mask_q;
`else
  logic [1:0]              cnt_q;
`endif

  logic consume;
  logic accept;

  assign OutValid = (state_q == EMIT);
  assign Imm26    = imm26_q;
  assign OutMovK  = movk_q;
  assign OutLast  = last_q;
  assign RangeErr = rerr_q;

  assign consume = OutValid && OutReady;
  assign InReady = (state_q == IDLE) || (consume && last_q);
  assign accept  = InValid && InReady;

  function automatic logic [25:0] im_field(input logic [1:0] h, input logic [15:0] chunk);
    return {3'b000, h, chunk, 5'b00000};
  endfunction

  // True when every bit of the upper slice equals the sign bit.
  function automatic logic all_same(input logic [63:0] v, input int lo);
    logic ones;
    logic zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i >= lo) begin
        ones  = ones & v[i];
        zeros = zeros & ~v[i];
      end
    end
    return ones | zeros;
  endfunction

  logic [25:0] sb_field;
  logic        sb_err;

  always_comb begin
    sb_field = '0;
    sb_err   = 1'b0;
    case (Ctrl[1:0])
      2'b00: begin
        sb_field[21:10] = Imm64[11:0];
        sb_err          = |Imm64[63:12];
      end
      2'b01: begin
        sb_field[20:12] = Imm64[8:0];
        sb_err          = !all_same(Imm64, 8);
      end
      2'b10: begin
        sb_field = Imm64[25:0];
        sb_err   = !all_same(Imm64, 25);
      end
      default: begin
        sb_field[23:5] = Imm64[18:0];
        sb_err         = !all_same(Imm64, 18);
      end
    endcase
  end

`ifdef IMM_ZERO_SKIP_EN
  function automatic logic [1:0] lowest(input logic [NUM_HW-1:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_HW - 1; i >= 0; i--) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  logic [NUM_HW-1:0] in_mask;
  logic [1:0]        first_h;
  logic [NUM_HW-1:0] first_rem;
  logic [1:0]        next_h;
  logic [NUM_HW-1:0] next_rem;

  always_comb begin
    in_mask = '0;
    for (int h = 0; h < NUM_HW; h++) begin
      in_mask[h] = |Imm64[16*h +: 16];
    end
    first_h   = lowest(in_mask);
    first_rem = in_mask & ~(NUM_HW'(1) << first_h);
    next_h    = lowest(mask_q);
    next_rem  = mask_q & ~(NUM_HW'(1) << next_h);
  end
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      imm26_q <= '0;
      movk_q  <= 1'b0;
      last_q  <= 1'b0;
      rerr_q  <= 1'b0;
      data_q  <= '0;
`ifdef IMM_ZERO_SKIP_EN
      mask_q  <= '0;
`else
      cnt_q   <= 2'd0;
`endif
    end else if (accept) begin
      state_q <= EMIT;
      data_q  <= Imm64;
      movk_q  <= 1'b0;
      if (Ctrl[2]) begin
        rerr_q <= 1'b0;
`ifdef IMM_ZERO_SKIP_EN
        // An all-zero constant falls out naturally: h = 0, chunk 0, nothing left.
        imm26_q <= im_field(first_h, Imm64[{first_h, 4'b0000} +: 16]);
        mask_q  <= first_rem;
        last_q  <= (first_rem == '0);
`else
        imm26_q <= im_field(2'd0, Imm64[15:0]);
        cnt_q   <= 2'd1;
        last_q  <= 1'b0;
`endif
      end else begin
        imm26_q <= sb_field;
        rerr_q  <= sb_err;
        last_q  <= 1'b1;
      end
    end else if (consume) begin
      if (last_q) begin
        state_q <= IDLE;
        imm26_q <= '0;
        movk_q  <= 1'b0;
        last_q  <= 1'b0;
        rerr_q  <= 1'b0;
      end else begin
        movk_q <= 1'b1;
`ifdef IMM_ZERO_SKIP_EN
        imm26_q <= im_field(next_h, data_q[{next_h, 4'b0000} +: 16]);
        mask_q  <= next_rem;
        last_q  <= (next_rem == '0);
`else
        imm26_q <= im_field(cnt_q, data_q[{cnt_q, 4'b0000} +: 16]);
        last_q  <= (cnt_q == 2'd3);
        cnt_q   <= cnt_q + 2'd1;
`endif
      end
    end
  end

endmodule

// File: doc/imm_field_encoder.md
Name: imm_field_encoder

Overview:
- Inverse of the datapath immediate sign extender: takes a 64-bit constant plus a format code and produces the 26-bit instruction immediate field(s) that the extender would decode back to that constant.
- Feeds the instruction-generation and self-test path.
- For I/D/B/CB formats it emits one beat with a range check.
- For the IM (MOVZ/MOVK) format it emits a multi-beat sequence of 16-bit chunks over a valid/ready output stream.

Parameters:
- NUM_HW, 4, number of 16-bit halfwords in a 64-bit constant; fixed at 4, for loop bounds only.

Ports:
- CLK  input  1  clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- InValid  input  1  request valid
- InReady  output  1  request accepted when InValid && InReady
- Imm64  input  64  constant to encode
- Ctrl  input  3  format code: 000 I, 001 D, 010 B, 011 CB, 1xx IM (same encoding as the sign extender)
- OutValid  output  1  beat valid
- OutReady  input  1  beat consumed when OutValid && OutReady
- Imm26  output  26  encoded immediate field
- OutMovK  output  1  IM beats only: 0 = MOVZ, 1 = MOVK; 0 for other formats
- OutLast  output  1  final beat of the request
- RangeErr  output  1  constant not representable in the format; valid with the beat

Behaviour:
- Reset (asynchronous, active-high): state IDLE; OutValid, OutLast, OutMovK, RangeErr, Imm26 = 0; InReady = 1. Any pending beats are dropped, and no partial sequence resumes after reset.
- States:
  - IDLE: output register empty.
  - EMIT: beat held in the output register.
- Handshake:
  - InReady = (state == IDLE) || (OutValid && OutReady && OutLast).
  - This allows back-to-back requests with no bubble.
  - First beat of a request is registered 1 cycle after acceptance.
  - While OutValid && !OutReady, all outputs are held stable.
- Field packing; unused bits of Imm26 are 0:
  - I (000): Imm26[21:10] = Imm64[11:0]. RangeErr = |Imm64[63:12] (unsigned 12-bit).
  - D (001): Imm26[20:12] = Imm64[8:0]. RangeErr = Imm64[63:8] not all equal (signed 9-bit).
  - B (010): Imm26 = Imm64[25:0]. RangeErr = Imm64[63:25] not all equal.
  - CB (011): Imm26[23:5] = Imm64[18:0]. RangeErr = Imm64[63:18] not all equal.
  - These four formats are single-beat, with OutLast = 1 and OutMovK = 0. RangeErr does not suppress the beat; the truncated field is still emitted.
- IM (1xx):
  - On acceptance, latch Imm64 and a 4-bit pending mask: bit h = (Imm64[16h+15:16h] != 0).
  - Each beat sets Imm26[20:5] = chunk, Imm26[22:21] = hw index h.
  - Beats go in ascending h order over pending chunks.
  - The first beat has OutMovK = 0; subsequent beats have OutMovK = 1.
  - On each consumed beat, clear that mask bit and load the next set bit.
  - OutLast = 1 when no other mask bit remains.
  - Imm64 == 0: a single beat, MOVZ, h = 0, chunk 0, OutLast = 1.
  - RangeErr is always 0.
- Beat count per request: 1 to 4. Next-chunk selection is a priority encode on the mask.
- Inputs are ignored when InReady = 0. Ctrl and Imm64 are sampled only at acceptance, so changes mid-sequence have no effect.

Optional Feature:
- Macro: IMM_ZERO_SKIP_EN.
- Defined: zero chunks are skipped, as described in Behaviour.
- Undefined: IM always emits exactly 4 beats, h = 0, 1, 2, 3 (MOVZ then 3 MOVK), including zero chunks. OutLast is asserted on the h = 3 beat. The pending mask reduces to a 2-bit beat counter.
- Non-IM formats are identical in both builds.

Test Plan:
1. I-type: Imm64 = 0x0000_0000_0000_0ABC, Ctrl = 000, OutReady = 1 -> next cycle Imm26 = 0x002AF000 (0xABC<<10), OutLast = 1, RangeErr = 0. Repeat with Imm64 = 0x1000 -> RangeErr = 1, Imm26 = 0.
2. CB/B sign range: Ctrl = 011, Imm64 = 0xFFFF_FFFF_FFFF_FFFC -> Imm26[23:5] = 0x7FFFC, RangeErr = 0. Ctrl = 010, Imm64 = 0x0000_0000_0200_0000 -> RangeErr = 1.
3. IM skip (IMM_ZERO_SKIP_EN): Imm64 = 0x1234_0000_0000_5678, OutReady = 1 -> beat 1: MOVZ, h = 0, chunk 0x5678, OutLast = 0. Beat 2: MOVK, h = 3, chunk 0x1234, OutLast = 1. Imm64 = 0 -> single MOVZ h = 0, chunk 0.
4. IM no-skip (macro undefined): Imm64 = 0x0000_00FF_0000_0001 -> 4 beats with (h, chunk) = (0, 0x0001), (1, 0), (2, 0x00FF), (3, 0). MovK = 0, 1, 1, 1; OutLast only on the 4th beat.
5. Backpressure and back-to-back:
   - Hold OutReady = 0 for 5 cycles mid-IM sequence -> Imm26, OutMovK, OutLast stable, InReady = 0.
   - Present a second request during the final consumed beat -> accepted that cycle, and its first beat is valid the next cycle (no bubble).
6. Reset mid-operation: assert Reset asynchronously during beat 2 of a 3-beat IM request -> OutValid drops immediately, InReady = 1 after release, and no further beats from the old request appear.
